// File: rtl/jtag_dtm_oversampled.sv
// jtag_dtm_oversampled: RISC-V 0.13 JTAG DTM clocked by clk, with TCK/TMS/TDI synchronised and oversampled
`timescale 1ns/1ps
module jtag_dtm_oversampled #(
    parameter logic [31:0] IDCODE_VAL = 32'h1E200A6D,
    parameter int ABITS = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             jtag_TCK,
    input  logic             jtag_TMS,
    input  logic             jtag_TDI,
    output logic             jtag_TDO,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_op
);
    localparam int DW = ABITS + 34;

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t state, state_next;
    logic [SYNC_STAGES-1:0][2:0] pin_sr;
    logic [2:0] pins;
    logic tck_d, rise, fall, rise_q, tms_q, tdi_q;
    logic [4:0] ir, ir_sh;
    logic [DW-1:0] dr_sh, dr_in, dmi_cap;
    logic [7:0] dr_len;
    logic [31:0] dtmcs_cap, resp_data_q;
    logic [1:0] resp_op_q, dmistat;
    logic sel_idcode, sel_dtmcs, sel_dmi;
    logic outstanding, sticky, busy, resp_hs, upd_dr;

    assign pins = pin_sr[SYNC_STAGES-1];
    assign rise = pins[2] & ~tck_d;
    assign fall = ~pins[2] & tck_d;

    // TMS/TDI are registered alongside the rise pulse so the TAP acts one cycle later on edge-time values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pin_sr <= '0;
            tck_d  <= 1'b0;
            rise_q <= 1'b0;
            tms_q  <= 1'b0;
            tdi_q  <= 1'b0;
        end else begin
            pin_sr <= {pin_sr[SYNC_STAGES-2:0], jtag_TCK, jtag_TMS, jtag_TDI};
            tck_d  <= pins[2];
            rise_q <= rise;
            tms_q  <= pins[1];
            tdi_q  <= pins[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= TLR;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (rise_q) begin
            case (state)
                TLR:    state_next = tms_q ? TLR    : RTI;
                RTI:    state_next = tms_q ? SEL_DR : RTI;
                SEL_DR: state_next = tms_q ? SEL_IR : CAP_DR;
                CAP_DR: state_next = tms_q ? EX1_DR : SH_DR;
                SH_DR:  state_next = tms_q ? EX1_DR : SH_DR;
                EX1_DR: state_next = tms_q ? UPD_DR : PA_DR;
                PA_DR:  state_next = tms_q ? EX2_DR : PA_DR;
                EX2_DR: state_next = tms_q ? UPD_DR : SH_DR;
                UPD_DR: state_next = tms_q ? SEL_DR : RTI;
                SEL_IR: state_next = tms_q ? TLR    : CAP_IR;
                CAP_IR: state_next = tms_q ? EX1_IR : SH_IR;
                SH_IR:  state_next = tms_q ? EX1_IR : SH_IR;
                EX1_IR: state_next = tms_q ? UPD_IR : PA_IR;
                PA_IR:  state_next = tms_q ? EX2_IR : PA_IR;
                EX2_IR: state_next = tms_q ? UPD_IR : SH_IR;
                UPD_IR: state_next = tms_q ? SEL_DR : RTI;
                default: state_next = TLR;
            endcase
        end
    end

    assign sel_idcode = ir == 5'h01;
    assign sel_dtmcs  = ir == 5'h10;
    assign sel_dmi    = ir == 5'h11;
    assign dr_len     = sel_dmi ? 8'(DW) : (sel_idcode | sel_dtmcs) ? 8'd32 : 8'd1;
    // TDI enters at the top of whichever register is selected; higher bits stay zero from capture
    assign dr_in      = {{(DW-1){1'b0}}, tdi_q} << (dr_len - 8'd1);
    assign dmistat    = sticky ? 2'd3 : resp_op_q;
    assign dtmcs_cap  = {14'b0, 2'b0, 1'b0, 3'd1, dmistat, 6'(ABITS), 4'd1};
    assign busy       = outstanding | sticky;
    assign dmi_cap    = {dmi_req_addr, resp_data_q, busy ? 2'd3 : resp_op_q};
    assign resp_hs    = dmi_resp_valid & outstanding;
    assign upd_dr     = rise_q & (state == UPD_DR);
    assign dmi_resp_ready = outstanding;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= 5'h01;
            ir_sh    <= '0;
            dr_sh    <= '0;
            jtag_TDO <= 1'b0;
        end else begin
            if (state == TLR) ir <= 5'h01;
            else if (rise_q) begin
                if (state == CAP_IR) ir_sh <= 5'b00001;
                if (state == SH_IR)  ir_sh <= {tdi_q, ir_sh[4:1]};
                if (state == UPD_IR) ir <= ir_sh;
                if (state == CAP_DR) dr_sh <= sel_dmi ? dmi_cap : sel_dtmcs ? DW'(dtmcs_cap) : sel_idcode ? DW'(IDCODE_VAL) : '0;
                if (state == SH_DR)  dr_sh <= (dr_sh >> 1) | dr_in;
            end
            if (fall && (state == SH_DR || state == SH_IR)) jtag_TDO <= (state == SH_IR) ? ir_sh[0] : dr_sh[0];
        end
    end

    // Later assignments take priority: a same-cycle response is retired before a DMI update is judged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmi_req_valid <= 1'b0;
            dmi_req_addr  <= '0;
            dmi_req_data  <= '0;
            dmi_req_op    <= '0;
            resp_data_q   <= '0;
            resp_op_q     <= '0;
            outstanding   <= 1'b0;
            sticky        <= 1'b0;
        end else begin
            if (dmi_req_valid && dmi_req_ready) dmi_req_valid <= 1'b0;
            if (resp_hs) begin
                resp_data_q <= dmi_resp_data;
                resp_op_q   <= dmi_resp_op;
                outstanding <= 1'b0;
            end
            if (rise_q && state == CAP_DR && sel_dmi && busy) sticky <= 1'b1;
            if (upd_dr && sel_dtmcs && (dr_sh[16] || dr_sh[17])) begin
                sticky    <= 1'b0;
                resp_op_q <= 2'd0;
            end
            if (upd_dr && sel_dtmcs && dr_sh[17]) begin
                dmi_req_valid <= 1'b0;
                outstanding   <= 1'b0;
            end
            if (upd_dr && sel_dmi && (dr_sh[1:0] == 2'd1 || dr_sh[1:0] == 2'd2) && !(outstanding && !resp_hs) && !sticky) begin
                dmi_req_addr  <= dr_sh[DW-1:34];
                dmi_req_data  <= dr_sh[33:2];
                dmi_req_op    <= dr_sh[1:0];
                dmi_req_valid <= 1'b1;
                outstanding   <= 1'b1;
            end
            if (state == TLR) sticky <= 1'b0;
        end
    end
endmodule
